// File: rtl/ula_share_arbiter_if.sv
// ula_share_arbiter_if
// Groups every signal between the arbiter and its surroundings, apart from
// the clock and reset.
//   req0_* / req1_*  : the two requesters' valid/ready handshakes and operands
//   ula_*            : operands and op code out to the shared ULA, plus its
//                      combinational result and zero flag coming back
//   rsp_*            : the captured response and its valid/ready handshake
//   served0/served1  : saturating counts of completed responses per requester
// Modports:
//   master : the environment (requesters, ULA, response consumer)
//   slave  : the arbiter
interface ula_share_arbiter_if #(
  parameter int DATA_W = 20,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_opA;
  logic [DATA_W-1:0] req0_opB;
  logic [1:0]        req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_opA;
  logic [DATA_W-1:0] req1_opB;
  logic [1:0]        req1_ctrl;

  logic [1:0]        ula_control;
  logic [DATA_W-1:0] ula_opA;
  logic [DATA_W-1:0] ula_opB;
  logic [DATA_W-1:0] ula_result;
  logic              ula_zero;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_ready;

  logic [CNT_W-1:0]  served0;
  logic [CNT_W-1:0]  served1;

  modport master (
    output req0_valid, req0_opA, req0_opB, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_opA, req1_opB, req1_ctrl,
    input  req1_ready,
    input  ula_control, ula_opA, ula_opB,
    output ula_result, ula_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    output rsp_ready,
    input  served0, served1
  );

  modport slave (
    input  req0_valid, req0_opA, req0_opB, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_opA, req1_opB, req1_ctrl,
    output req1_ready,
    output ula_control, ula_opA, ula_opB,
    input  ula_result, ula_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  rsp_ready,
    output served0, served1
  );
endinterface

// File: rtl/ula_share_arbiter.sv
// ula_share_arbiter
// Shares one combinational ULA between two requesters. A grant in IDLE
// latches the winner's operands, EXEC spends one cycle letting the ULA settle
// and captures its outputs, and RESP holds the response until the consumer
// takes it. Arbitration is round-robin, and the preference flips to the other
// requester each time a response is taken.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : ula_share_arbiter_if slave modport (requests, ULA, response, counters)
module ula_share_arbiter #(
  parameter int DATA_W = 20,
  parameter int CNT_W  = 16
) (
  input logic               clock,
  input logic               reset,
  ula_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              prio;
  logic              owner;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [1:0]        op_ctrl;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [CNT_W-1:0]  served0_q;
  logic [CNT_W-1:0]  served1_q;

  logic grant_valid;
  logic grant_id;
  logic rsp_valid_c;
  logic handshake;

  // Readies and rsp_valid are masked during reset, so a requester or the
  // consumer never sees a handshake in a cycle the reset is going to discard.
  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (bus.req0_valid || bus.req1_valid)) begin
          grant_valid = 1'b1;
          // Prefer prio when both compete; otherwise take whoever is asking.
          grant_id    = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
          next_state  = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        rsp_valid_c = !reset;
        if (bus.rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign handshake = rsp_valid_c && bus.rsp_ready;

  // State, operand, response and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_ctrl   <= 2'b00;
      result_q  <= '0;
      zero_q    <= 1'b0;
      served0_q <= '0;
      served1_q <= '0;
    end else begin
      state <= next_state;
      if (grant_valid) begin
        owner   <= grant_id;
        op_a    <= grant_id ? bus.req1_opA  : bus.req0_opA;
        op_b    <= grant_id ? bus.req1_opB  : bus.req0_opB;
        op_ctrl <= grant_id ? bus.req1_ctrl : bus.req0_ctrl;
      end
      if (state == EXEC) begin
        result_q <= bus.ula_result;
        zero_q   <= bus.ula_zero;
      end
      if (handshake) begin
        prio <= ~owner;
        // Counters stick at all-ones rather than wrapping back to zero.
        if (!owner && (served0_q != '1)) begin
          served0_q <= served0_q + 1'b1;
        end
        if (owner && (served1_q != '1)) begin
          served1_q <= served1_q + 1'b1;
        end
      end
    end
  end

  assign bus.req0_ready  = grant_valid && !grant_id;
  assign bus.req1_ready  = grant_valid && grant_id;
  assign bus.ula_control = op_ctrl;
  assign bus.ula_opA     = op_a;
  assign bus.ula_opB     = op_b;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_id      = owner;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.served0     = served0_q;
  assign bus.served1     = served1_q;

endmodule

// File: tb/tb_ula_share_arbiter.sv
// tb_ula_share_arbiter
// Drives directed operations into the arbiter. Each grant pushes the expected
// response onto a scoreboard queue, and a negedge monitor compares it with
// whatever the arbiter presents. The served counters are 2 bits wide here, so
// the saturation case can be reached in a few operations.
module tb_ula_share_arbiter;

  localparam int DATA_W = 20;
  localparam int CNT_W  = 2;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] result;
    logic              zero;
    int                cyc;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_fail;
  logic prev_valid;
  logic [CNT_W-1:0] exp_served0;
  logic [CNT_W-1:0] exp_served1;
  exp_t sb_q[$];

  ula_share_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

  ula_share_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // Clock, plus a cycle count for checking response latency.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural stand-in for the shared ULA.
  always_comb begin
    case (bus_if.ula_control)
      2'b00:   bus_if.ula_result = bus_if.ula_opA + bus_if.ula_opB;
      2'b01:   bus_if.ula_result = bus_if.ula_opA | bus_if.ula_opB;
      2'b10:   bus_if.ula_result = bus_if.ula_opA & bus_if.ula_opB;
      default: bus_if.ula_result = ~bus_if.ula_opA;
    endcase
    bus_if.ula_zero = (bus_if.ula_opA == bus_if.ula_opB);
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Monitor: compares the held response against the queue head every cycle
  // it is valid, checks latency on its first cycle, and pops on handshake.
  initial prev_valid = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      check_output("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'(0));
      check_output("reset_ready", 32'({bus_if.req1_ready, bus_if.req0_ready}), 32'(0));
    end else if (bus_if.rsp_valid) begin
      if (sb_q.size() == 0) begin
        check_output("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        check_output("rsp_id", 32'(bus_if.rsp_id), 32'(sb_q[0].id));
        check_output("rsp_result", 32'(bus_if.rsp_result), 32'(sb_q[0].result));
        check_output("rsp_zero", 32'(bus_if.rsp_zero), 32'(sb_q[0].zero));
        check_output("ready_in_resp", 32'({bus_if.req1_ready, bus_if.req0_ready}), 32'(0));
        if (!prev_valid) begin
          check_output("latency", 32'(cyc), 32'(sb_q[0].cyc + 2));
        end
        if (bus_if.rsp_ready) begin
          check_output("served0", 32'(bus_if.served0), 32'(exp_served0));
          check_output("served1", 32'(bus_if.served1), 32'(exp_served1));
          if (!sb_q[0].id && exp_served0 != '1) exp_served0 = exp_served0 + 1'b1;
          if (sb_q[0].id && exp_served1 != '1) exp_served1 = exp_served1 + 1'b1;
          void'(sb_q.pop_front());
        end
      end
    end
    prev_valid = bus_if.rsp_valid && !reset;
  end

  // Presents the requests in vmask, waits for a grant, checks who won and
  // queues the expected response. drop clears both valids after the grant.
  task automatic apply_stimulus(input logic [1:0] vmask,
                                input logic [1:0] c0, input logic [DATA_W-1:0] a0,
                                input logic [DATA_W-1:0] b0,
                                input logic [1:0] c1, input logic [DATA_W-1:0] a1,
                                input logic [DATA_W-1:0] b1,
                                input logic exp_id, input logic [DATA_W-1:0] exp_res,
                                input logic exp_zero, input logic drop);
    logic got;
    exp_t e;
    got = 1'b0;
    bus_if.req0_valid = vmask[0];
    bus_if.req0_ctrl  = c0;
    bus_if.req0_opA   = a0;
    bus_if.req0_opB   = b0;
    bus_if.req1_valid = vmask[1];
    bus_if.req1_ctrl  = c1;
    bus_if.req1_opA   = a1;
    bus_if.req1_opB   = b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus_if.req0_ready || bus_if.req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check_output("grant_timeout", 32'(0), 32'(1));
    end else begin
      check_output("grant_id", 32'(bus_if.req1_ready), 32'(exp_id));
      check_output("ready_onehot", 32'(bus_if.req0_ready && bus_if.req1_ready), 32'(0));
      e.id     = exp_id;
      e.result = exp_res;
      e.zero   = exp_zero;
      e.cyc    = cyc;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
    if (drop) begin
      bus_if.req0_valid = 1'b0;
      bus_if.req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (sb_q.size() == 0 && !bus_if.rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_output("idle_timeout", 32'(0), 32'(1));
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp_valid();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus_if.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_output("rsp_valid_timeout", 32'(0), 32'(1));
  endtask

  // Contention table: req0 adds 5+3, req1 ANDs 7&7 (equal operands -> zero).
  localparam logic [DATA_W-1:0] C0_RES = 20'h00008;
  localparam logic [DATA_W-1:0] C1_RES = 20'h00007;

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    exp_served0 = '0;
    exp_served1 = '0;
    reset       = 1'b1;
    bus_if.rsp_ready  = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_ctrl  = 2'b00;
    bus_if.req0_opA   = 20'h00001;
    bus_if.req0_opB   = 20'h00001;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_ctrl  = 2'b00;
    bus_if.req1_opA   = '0;
    bus_if.req1_opB   = '0;

    // Reset: a request present during reset must not be granted.
    @(posedge clock);
    @(negedge clock);
    check_output("reset_req0_ready", 32'(bus_if.req0_ready), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus_if.req0_valid = 1'b0;
    @(negedge clock);
    check_output("post_reset_rsp_valid", 32'(bus_if.rsp_valid), 32'(0));
    check_output("post_reset_ctrl", 32'(bus_if.ula_control), 32'(0));
    check_output("post_reset_opA", 32'(bus_if.ula_opA), 32'(0));
    check_output("post_reset_opB", 32'(bus_if.ula_opB), 32'(0));
    check_output("post_reset_result", 32'(bus_if.rsp_result), 32'(0));
    check_output("post_reset_zero", 32'(bus_if.rsp_zero), 32'(0));
    check_output("post_reset_id", 32'(bus_if.rsp_id), 32'(0));
    check_output("post_reset_served0", 32'(bus_if.served0), 32'(0));
    check_output("post_reset_served1", 32'(bus_if.served1), 32'(0));
    @(posedge clock);
    #1;

    // Contention: both held valid, grants alternate starting with 0.
    apply_stimulus(2'b11, 2'b00, 20'h5, 20'h3, 2'b10, 20'h7, 20'h7, 1'b0, C0_RES, 1'b0, 1'b0);
    apply_stimulus(2'b11, 2'b00, 20'h5, 20'h3, 2'b10, 20'h7, 20'h7, 1'b1, C1_RES, 1'b1, 1'b0);
    apply_stimulus(2'b11, 2'b00, 20'h5, 20'h3, 2'b10, 20'h7, 20'h7, 1'b0, C0_RES, 1'b0, 1'b0);
    apply_stimulus(2'b11, 2'b00, 20'h5, 20'h3, 2'b10, 20'h7, 20'h7, 1'b1, C1_RES, 1'b1, 1'b1);
    wait_idle();

    // Single op: 1 + 1 = 2, equal operands so zero is set.
    apply_stimulus(2'b01, 2'b00, 20'h00001, 20'h00001, 2'b00, '0, '0, 1'b0, 20'h00002, 1'b1, 1'b1);
    wait_idle();

    // Backpressure: OR held for 5 extra cycles with rsp_ready low.
    bus_if.rsp_ready = 1'b0;
    apply_stimulus(2'b10, 2'b00, '0, '0, 2'b01, 20'hFFC00, 20'h00003, 1'b1, 20'hFFC03, 1'b0, 1'b1);
    wait_rsp_valid();
    repeat (5) @(negedge clock);
    @(posedge clock);
    #1;
    bus_if.rsp_ready = 1'b1;
    wait_idle();

    // NOT of 0xFFC00 on requester 1.
    apply_stimulus(2'b10, 2'b00, '0, '0, 2'b11, 20'hFFC00, 20'h00000, 1'b1, 20'h003FF, 1'b0, 1'b1);
    wait_idle();

    // Add wraps: 0xFFFFF + 1 = 0. Served by req0, so prio is now 1.
    apply_stimulus(2'b01, 2'b00, 20'hFFFFF, 20'h00001, 2'b00, '0, '0, 1'b0, 20'h00000, 1'b0, 1'b1);
    wait_idle();

    // Reset while the response is held: it is discarded, counters and prio clear.
    bus_if.rsp_ready = 1'b0;
    apply_stimulus(2'b01, 2'b01, 20'h00F00, 20'h000F0, 2'b00, '0, '0, 1'b0, 20'h00FF0, 1'b0, 1'b1);
    wait_rsp_valid();
    @(posedge clock);
    #1;
    reset = 1'b1;
    sb_q.delete();
    exp_served0 = '0;
    exp_served1 = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(negedge clock);
    check_output("rst_resp_rsp_valid", 32'(bus_if.rsp_valid), 32'(0));
    check_output("rst_resp_served0", 32'(bus_if.served0), 32'(0));
    check_output("rst_resp_served1", 32'(bus_if.served1), 32'(0));
    check_output("rst_resp_opA", 32'(bus_if.ula_opA), 32'(0));
    @(posedge clock);
    #1;
    // With prio back at 0, requester 0 wins the tie.
    apply_stimulus(2'b11, 2'b00, 20'h5, 20'h3, 2'b10, 20'h7, 20'h7, 1'b0, C0_RES, 1'b0, 1'b1);
    wait_idle();

    // Saturation: three more req0 ops take the 2-bit served0 past 3.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(2'b01, 2'b10, 20'h0F0F0, 20'h00FF0, 2'b00, '0, '0, 1'b0, 20'h000F0, 1'b0, 1'b1);
      wait_idle();
    end
    @(negedge clock);
    check_output("saturated_served0", 32'(bus_if.served0), 32'(3));
    check_output("final_served1", 32'(bus_if.served1), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
